// File: rtl/pack_fifo_buffer.sv
// pack_fifo_buffer: width-packing circular FIFO.
// A narrow producer writes PAR_WRITE words per accepted write; a wide
// consumer reads PAR_READ words per accepted read. Flags derive purely
// from the occupancy count. Storage is a plain register array without reset.
module pack_fifo_buffer #(
    parameter int NUM_BIT   = 4,
    parameter int NUM_REG   = 8,
    parameter int ADDR_REG  = 3,
    parameter int PAR_WRITE = 1,
    parameter int PAR_READ  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          write_en,
    input  logic                          read_en,
    input  logic [PAR_WRITE*NUM_BIT-1:0]  din,
    output logic [PAR_READ*NUM_BIT-1:0]   dout,
    output logic                          full,
    output logic                          empty,
    output logic                          ready,
    output logic                          valid
);

    // Constants sized to the count width (ADDR_REG+1 bits holds 0..NUM_REG).
    localparam logic [ADDR_REG:0]   DEPTH_C = (ADDR_REG+1)'(NUM_REG);
    localparam logic [ADDR_REG:0]   PW_C    = (ADDR_REG+1)'(PAR_WRITE);
    localparam logic [ADDR_REG:0]   PR_C    = (ADDR_REG+1)'(PAR_READ);
    // Pointer increments; a group as large as the whole array wraps to zero.
    localparam logic [ADDR_REG-1:0] PW_STEP = ADDR_REG'(PAR_WRITE % NUM_REG);
    localparam logic [ADDR_REG-1:0] PR_STEP = ADDR_REG'(PAR_READ % NUM_REG);

    // Storage and state
    logic [NUM_BIT-1:0]                  mem_reg [NUM_REG];
    logic [ADDR_REG-1:0]                 wp_reg, wp_next;
    logic [ADDR_REG-1:0]                 rp_reg, rp_next;
    logic [ADDR_REG:0]                   count_reg, count_next;
    logic [PAR_READ*NUM_BIT-1:0]         dout_reg, dout_next;
    logic                                valid_reg, valid_next;

    // Datapath helpers
    logic [ADDR_REG:0]                   free_cnt;
    logic                                wr_accept;
    logic                                rd_accept;
    logic [NUM_REG-1:0][NUM_BIT-1:0]     pad_word;   // din words, zero padded to NUM_REG
    logic [NUM_REG-1:0][ADDR_REG-1:0]    win_idx;    // entry offset from write pointer
    logic [NUM_REG-1:0]                  win_hit;    // entry lies inside the write window
    logic [PAR_READ-1:0][ADDR_REG-1:0]   rd_addr;
    logic [PAR_READ*NUM_BIT-1:0]         rd_data;

    // Status flags are a pure function of the occupancy count.
    assign free_cnt  = DEPTH_C - count_reg;
    assign full      = free_cnt < PW_C;
    assign empty     = count_reg < PR_C;
    assign ready     = ~full;

    // Acceptance uses pre-edge flags: a same-cycle read never rescues a
    // write blocked by full, nor does a write rescue a read blocked by empty.
    assign wr_accept = write_en & ~full;
    assign rd_accept = read_en & ~empty;

    assign dout  = dout_reg;
    assign valid = valid_reg;

    // Spread the write lanes over a NUM_REG-wide word vector so every entry
    // can select its source word with a full-width pointer offset.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REG; gi++) begin : g_pad
            if (gi < PAR_WRITE) begin : g_lane
                assign pad_word[gi] = din[gi*NUM_BIT +: NUM_BIT];
            end else begin : g_zero
                assign pad_word[gi] = '0;
            end
        end
    endgenerate

    // Each entry computes its distance from the write pointer (mod NUM_REG);
    // distances below PAR_WRITE are the entries written this cycle.
    generate
        for (gi = 0; gi < NUM_REG; gi++) begin : g_window
            assign win_idx[gi] = ADDR_REG'(gi) - wp_reg;
            assign win_hit[gi] = {1'b0, win_idx[gi]} < PW_C;
        end
    endgenerate

    // Read lanes: word j of the output comes from rp+j, wrapping naturally.
    generate
        for (gi = 0; gi < PAR_READ; gi++) begin : g_read
            assign rd_addr[gi] = rp_reg + ADDR_REG'(gi);
            assign rd_data[gi*NUM_BIT +: NUM_BIT] = mem_reg[rd_addr[gi]];
        end
    endgenerate

    // Storage array write; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REG; i++) begin
            if (wr_accept && win_hit[i]) begin
                mem_reg[i] <= pad_word[win_idx[i]];
            end
        end
    end

    // Next-state computation for pointers, count and the registered output.
    always_comb begin
        wp_next    = wp_reg;
        rp_next    = rp_reg;
        count_next = count_reg;
        dout_next  = dout_reg;
        valid_next = 1'b0;
        if (wr_accept) begin
            wp_next = wp_reg + PW_STEP;
        end
        if (rd_accept) begin
            rp_next    = rp_reg + PR_STEP;
            dout_next  = rd_data;
            valid_next = 1'b1;
        end
        count_next = count_reg + (wr_accept ? PW_C : '0) - (rd_accept ? PR_C : '0);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_reg    <= '0;
            rp_reg    <= '0;
            count_reg <= '0;
            dout_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            wp_reg    <= wp_next;
            rp_reg    <= rp_next;
            count_reg <= count_next;
            dout_reg  <= dout_next;
            valid_reg <= valid_next;
        end
    end

endmodule

// File: tb/tb_pack_fifo_buffer.sv
// Self-checking bench for pack_fifo_buffer: directed steps plus random
// traffic, compared against a word-queue reference model.
module tb_pack_fifo_buffer;

    localparam int NB = 4;
    localparam int NR = 8;
    localparam int AR = 3;
    localparam int PW = 1;
    localparam int PR = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               write_en;
    logic               read_en;
    logic [PW*NB-1:0]   din;
    logic [PR*NB-1:0]   dout;
    logic               full;
    logic               empty;
    logic               ready;
    logic               valid;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO of words plus the last delivered read group.
    logic [NB-1:0]      q[$];
    logic [PR*NB-1:0]   exp_dout;
    logic [7:0]         rd_exp [4];

    pack_fifo_buffer #(
        .NUM_BIT(NB), .NUM_REG(NR), .ADDR_REG(AR),
        .PAR_WRITE(PW), .PAR_READ(PR)
    ) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
        .din(din), .dout(dout), .full(full), .empty(empty),
        .ready(ready), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of requests, advance the model, then compare all outputs.
    task automatic step(input logic we, input logic re, input logic [NB-1:0] d, input string tag);
        int  sz;
        bit  wr_ok;
        bit  rd_ok;
        sz    = q.size();
        wr_ok = we && ((NR - sz) >= PW);
        rd_ok = re && (sz >= PR);
        write_en = we;
        read_en  = re;
        din      = d;
        if (rd_ok) begin
            for (int j = 0; j < PR; j++) exp_dout[j*NB +: NB] = q.pop_front();
        end
        if (wr_ok) q.push_back(d);
        @(posedge clk);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        check({tag, ".dout"},  dout,  exp_dout);
        check({tag, ".valid"}, valid, rd_ok);
        check({tag, ".full"},  full,  (NR - q.size()) < PW);
        check({tag, ".empty"}, empty, q.size() < PR);
        check({tag, ".ready"}, ready, (NR - q.size()) >= PW);
        $display("step %-12s we=%0b re=%0b din=%h -> dout=%h valid=%0b full=%0b empty=%0b words=%0d",
                 tag, we, re, d, dout, valid, full, empty, q.size());
    endtask

    // Assert reset off-edge, check the asynchronous effect, hold, release mid-cycle.
    task automatic do_reset(input string tag);
        #2;
        write_en = 1'b0;
        read_en  = 1'b0;
        rst = 1'b0;
        q.delete();
        exp_dout = '0;
        #1;
        check({tag, ".dout"},  dout,  '0);
        check({tag, ".valid"}, valid, 1'b0);
        check({tag, ".empty"}, empty, 1'b1);
        check({tag, ".full"},  full,  1'b0);
        check({tag, ".ready"}, ready, 1'b1);
        $display("reset %-11s dout=%h valid=%0b full=%0b empty=%0b ready=%0b",
                 tag, dout, valid, full, empty, ready);
        #100;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        din      = '0;
        exp_dout = '0;
        rd_exp[0] = 8'h10;
        rd_exp[1] = 8'h32;
        rd_exp[2] = 8'h54;
        rd_exp[3] = 8'h76;

        // Reset state
        do_reset("init");

        // Basic pack: A then 3, read yields 3A
        step(1'b1, 1'b0, 4'hA, "pack_w0");
        step(1'b1, 1'b0, 4'h3, "pack_w1");
        step(1'b0, 1'b1, 4'h0, "pack_rd");
        check("pack.const", dout, 8'h3A);
        step(1'b0, 1'b0, 4'h0, "pack_idle");
        check("pack.empty_after", empty, 1'b1);

        // Underflow: one word stored, read must be ignored
        step(1'b1, 1'b0, 4'h5, "under_w");
        check("under.empty", empty, 1'b1);
        step(1'b0, 1'b1, 4'h0, "under_rd");
        check("under.hold", dout, 8'h3A);

        // Full and wrap-around from a clean state
        do_reset("pre_full");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i), "fill");
        check("full.flag", full, 1'b1);
        check("full.ready", ready, 1'b0);
        step(1'b1, 1'b0, 4'hF, "over_w");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 4'h0, "drain");
            check("drain.const", dout, rd_exp[i]);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'($urandom_range(0, 15)), "wrap_w");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h0, "wrap_rd");
        check("wrap.empty", empty, 1'b1);

        // Simultaneous read and write at count 2
        step(1'b1, 1'b0, 4'h1, "sim_w0");
        step(1'b1, 1'b0, 4'h2, "sim_w1");
        step(1'b1, 1'b1, 4'h9, "sim_rw");
        check("sim.const", dout, 8'h21);
        check("sim.empty", empty, 1'b1);

        // Simultaneous at full: read wins, write rejected
        while (q.size() < NR) step(1'b1, 1'b0, 4'($urandom_range(0, 15)), "refill");
        step(1'b1, 1'b1, 4'hE, "full_rw");
        check("full_rw.full", full, 1'b0);
        step(1'b0, 1'b1, 4'h0, "full_rw_r1");
        step(1'b0, 1'b1, 4'h0, "full_rw_r2");
        step(1'b0, 1'b1, 4'h0, "full_rw_r3");
        check("full_rw.drained", empty, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
                 4'($urandom_range(0, 15)), "rand");
        end

        // Reset mid-operation at count 5
        while (q.size() >= PR) step(1'b0, 1'b1, 4'h0, "pre_drain");
        while (q.size() < 5) step(1'b1, 1'b0, 4'($urandom_range(0, 15)), "pre_fill");
        do_reset("mid_op");
        step(1'b0, 1'b1, 4'h0, "post_rd");
        check("post_rd.valid", valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
